// File: rtl/flag_update_sequencer_pkg.sv
// Shared condition-code defines, pipe-entry type and helpers for flag_update_sequencer.
// The defines mirror the codebase defines.v; guarded so a second definition is harmless.
`ifndef FLAG_SEQ_DEFINES
`define FLAG_SEQ_DEFINES
`define COND_CODE_WIDTH 4
`define EQ 4'h0
`define NE 4'h1
`define GE 4'hA
`define LT 4'hB
`define GT 4'hC
`define LE 4'hD
`define AL 4'hE
`define DSP_LAT_DEFAULT 4
`endif

package flag_update_sequencer_pkg;

  typedef logic [`COND_CODE_WIDTH-1:0] cond_t;

  typedef struct packed {
    logic  valid;
    logic  setflags;
    cond_t condcode;
  } stage_t;

  localparam cond_t CondAl = `AL;

  function automatic logic is_conditional(input cond_t cc);
    return cc != CondAl;
  endfunction

endpackage

// File: rtl/flag_update_sequencer_pipe_stage.sv
// One entry of the flag-writer tracking pipe; FLUSH_CLR kills the incoming entry on flush.
module flag_pipe_stage
  import flag_update_sequencer_pkg::*;
#(
  parameter bit FLUSH_CLR = 1'b0
) (
  input  logic   clk,
  input  logic   rst,
  input  logic   i_flush,
  input  stage_t i_d,
  output stage_t o_q
);

  stage_t r_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_q.valid    <= 1'b0;
      r_q.setflags <= 1'b0;
      r_q.condcode <= CondAl;
    end else begin
      r_q <= i_d;
      if (FLUSH_CLR && i_flush) begin
        r_q.valid <= 1'b0;
      end
    end
  end

  assign o_q = r_q;

endmodule

// File: rtl/flag_update_sequencer.sv
// Tracks flag-setting instructions through the DSP execute pipe, aligns sr_we_o with P and
// stalls dependent conditionals. Optional stall counter under FLAG_STALL_CNT_EN.
module flag_update_sequencer
  import flag_update_sequencer_pkg::*;
#(
  parameter int unsigned DSP_LAT  = `DSP_LAT_DEFAULT,
  parameter int unsigned COND_LAT = 2
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         issue_valid_i,
  input  logic                         issue_setflags_i,
  input  logic [`COND_CODE_WIDTH-1:0]  issue_condcode_i,
  output logic                         ready_o,
  input  logic                         flush_i,
  output logic                         sr_we_o,
  output logic [`COND_CODE_WIDTH-1:0]  condcode_o,
  output logic                         cond_valid_o,
  output logic [$clog2(DSP_LAT+1)-1:0] pending_o
`ifdef FLAG_STALL_CNT_EN
  ,
  output logic [15:0]                  stall_cnt_o
`endif
);

  localparam int unsigned HAZ_WIN = DSP_LAT - COND_LAT;
  localparam int unsigned PW      = $clog2(DSP_LAT + 1);

  stage_t w_stage_d [DSP_LAT];
  stage_t w_stage_q [DSP_LAT];
  logic   w_accept;
  logic [PW-1:0] w_pending;

  assign w_accept = issue_valid_i & ready_o & ~flush_i;

  // Stages below COND_LAT receive entries that have not yet reached evaluation.
  for (genvar k = 0; k < DSP_LAT; k++) begin : g_stage
    if (k == 0) begin : g_in
      assign w_stage_d[k] = '{valid: w_accept, setflags: issue_setflags_i,
                              condcode: issue_condcode_i};
    end else begin : g_link
      assign w_stage_d[k] = w_stage_q[k-1];
    end

    flag_pipe_stage #(
      .FLUSH_CLR(k < COND_LAT)
    ) u_stage (
      .clk    (clk),
      .rst    (rst),
      .i_flush(flush_i),
      .i_d    (w_stage_d[k]),
      .o_q    (w_stage_q[k])
    );
  end

  if (HAZ_WIN == 0) begin : g_no_haz
    assign ready_o = 1'b1;
  end else begin : g_haz
    logic w_hazard;
    always_comb begin
      w_hazard = 1'b0;
      for (int unsigned k = 0; k < HAZ_WIN; k++) begin
        w_hazard = w_hazard | (w_stage_q[k].valid & w_stage_q[k].setflags);
      end
    end
    assign ready_o = ~(issue_valid_i & is_conditional(issue_condcode_i) & w_hazard);
  end

  // Live writer count equals flag-setting entries present in the pipe.
  always_comb begin
    w_pending = '0;
    for (int unsigned k = 0; k < DSP_LAT; k++) begin
      w_pending = w_pending + PW'(w_stage_q[k].valid & w_stage_q[k].setflags);
    end
  end

  assign pending_o    = w_pending;
  assign sr_we_o      = w_stage_q[DSP_LAT-1].valid & w_stage_q[DSP_LAT-1].setflags;
  assign cond_valid_o = w_stage_q[COND_LAT-1].valid;
  assign condcode_o   = w_stage_q[COND_LAT-1].valid ? w_stage_q[COND_LAT-1].condcode : CondAl;

`ifdef FLAG_STALL_CNT_EN
  logic [15:0] r_stall_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_stall_cnt <= '0;
    end else if (issue_valid_i && !ready_o && r_stall_cnt != 16'hFFFF) begin
      r_stall_cnt <= r_stall_cnt + 16'd1;
    end
  end

  assign stall_cnt_o = r_stall_cnt;
`endif

endmodule

// File: tb/tb_flag_update_sequencer.sv
// Directed self-checking bench for flag_update_sequencer at DSP_LAT=4, COND_LAT=2.
module tb_flag_update_sequencer;

  localparam logic [3:0] CcEq = 4'h0;
  localparam logic [3:0] CcAl = 4'hE;

  logic       clk = 1'b0;
  logic       rst;
  logic       issue_valid;
  logic       issue_setflags;
  logic [3:0] issue_condcode;
  logic       ready;
  logic       flush;
  logic       sr_we;
  logic [3:0] condcode;
  logic       cond_valid;
  logic [2:0] pending;
`ifdef FLAG_STALL_CNT_EN
  logic [15:0] stall_cnt;
`endif

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  flag_update_sequencer #(
    .DSP_LAT (4),
    .COND_LAT(2)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .issue_valid_i   (issue_valid),
    .issue_setflags_i(issue_setflags),
    .issue_condcode_i(issue_condcode),
    .ready_o         (ready),
    .flush_i         (flush),
    .sr_we_o         (sr_we),
    .condcode_o      (condcode),
    .cond_valid_o    (cond_valid),
    .pending_o       (pending)
`ifdef FLAG_STALL_CNT_EN
    ,
    .stall_cnt_o     (stall_cnt)
`endif
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic drive(input logic v, input logic sf, input logic [3:0] cc, input logic fl);
    issue_valid    = v;
    issue_setflags = sf;
    issue_condcode = cc;
    flush          = fl;
  endtask

  // Inputs change 1 time unit after posedge; checks happen at the following negedge.
  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    drive(1'b0, 1'b0, CcAl, 1'b0);
    for (int i = 0; i < n; i++) next_cycle();
  endtask

  logic [2:0] exp_pend [8];
  logic       exp_we   [8];

  initial begin
    rst = 1'b1;
    drive(1'b1, 1'b1, CcEq, 1'b0);
    next_cycle();
    next_cycle();
    @(negedge clk);
    check_eq("rst_ready", ready, 1);
    check_eq("rst_sr_we", sr_we, 0);
    check_eq("rst_cond_valid", cond_valid, 0);
    check_eq("rst_condcode", condcode, CcAl);
    check_eq("rst_pending", pending, 0);
`ifdef FLAG_STALL_CNT_EN
    check_eq("rst_stall_cnt", stall_cnt, 0);
`endif
    next_cycle();
    rst = 1'b0;
    idle(1);

    // Single unconditional flag writer.
    drive(1'b1, 1'b1, CcAl, 1'b0);
    @(negedge clk);
    check_eq("s1_ready_c0", ready, 1);
    next_cycle();
    drive(1'b0, 1'b0, CcAl, 1'b0);
    for (int c = 1; c <= 5; c++) begin
      @(negedge clk);
      check_eq($sformatf("s1_pending_c%0d", c), pending, (c <= 4) ? 1 : 0);
      check_eq($sformatf("s1_sr_we_c%0d", c), sr_we, (c == 4) ? 1 : 0);
      next_cycle();
    end
    idle(2);

    // Hazard: EQ consumer behind an AL flag writer.
    drive(1'b1, 1'b1, CcAl, 1'b0);
    @(negedge clk);
    check_eq("hz_ready_c0", ready, 1);
    next_cycle();
    drive(1'b1, 1'b0, CcEq, 1'b0);
    @(negedge clk);
    check_eq("hz_ready_c1", ready, 0);
    next_cycle();
    @(negedge clk);
    check_eq("hz_ready_c2", ready, 0);
    next_cycle();
    @(negedge clk);
    check_eq("hz_ready_c3", ready, 1);
    next_cycle();
    drive(1'b0, 1'b0, CcAl, 1'b0);
    @(negedge clk);
    check_eq("hz_sr_we_c4", sr_we, 1);
    check_eq("hz_cond_valid_c4", cond_valid, 0);
    check_eq("hz_condcode_c4", condcode, CcAl);
`ifdef FLAG_STALL_CNT_EN
    check_eq("hz_stall_cnt", stall_cnt, 2);
`endif
    next_cycle();
    @(negedge clk);
    check_eq("hz_sr_we_c5", sr_we, 0);
    check_eq("hz_cond_valid_c5", cond_valid, 1);
    check_eq("hz_condcode_c5", condcode, CcEq);
    next_cycle();
    @(negedge clk);
    check_eq("hz_cond_valid_c6", cond_valid, 0);
    idle(5);

    // Back-to-back unconditional writers never stall.
    exp_pend = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd3, 3'd2, 3'd1, 3'd0};
    exp_we   = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
    for (int c = 0; c < 8; c++) begin
      drive(c < 3, 1'b1, CcAl, 1'b0);
      @(negedge clk);
      if (c < 3) check_eq($sformatf("b2b_ready_c%0d", c), ready, 1);
      check_eq($sformatf("b2b_pending_c%0d", c), pending, exp_pend[c]);
      check_eq($sformatf("b2b_sr_we_c%0d", c), sr_we, exp_we[c]);
      next_cycle();
    end
    idle(2);

    // Flush while the writer is in stage 0: writer and new issue are both killed.
    drive(1'b1, 1'b1, CcAl, 1'b0);
    next_cycle();
    drive(1'b1, 1'b1, CcAl, 1'b1);
    @(negedge clk);
    check_eq("fl0_pending_c1", pending, 1);
    next_cycle();
    drive(1'b0, 1'b0, CcAl, 1'b0);
    for (int c = 2; c <= 6; c++) begin
      @(negedge clk);
      check_eq($sformatf("fl0_pending_c%0d", c), pending, 0);
      check_eq($sformatf("fl0_sr_we_c%0d", c), sr_we, 0);
      next_cycle();
    end
    idle(2);

    // Flush while the writer sits at the condition stage: it survives.
    drive(1'b1, 1'b1, CcAl, 1'b0);
    next_cycle();
    drive(1'b0, 1'b0, CcAl, 1'b0);
    next_cycle();
    drive(1'b0, 1'b0, CcAl, 1'b1);
    @(negedge clk);
    check_eq("fl1_cond_valid_c2", cond_valid, 1);
    next_cycle();
    drive(1'b0, 1'b0, CcAl, 1'b0);
    @(negedge clk);
    check_eq("fl1_pending_c3", pending, 1);
    next_cycle();
    @(negedge clk);
    check_eq("fl1_sr_we_c4", sr_we, 1);
    idle(3);

    // Conditional flag setter with empty pipe is accepted at once.
    drive(1'b1, 1'b1, CcEq, 1'b0);
    @(negedge clk);
    check_eq("csf_ready_c0", ready, 1);
    next_cycle();
    drive(1'b1, 1'b1, CcEq, 1'b0);
    @(negedge clk);
    check_eq("csf_ready_c1", ready, 0);
    next_cycle();
    drive(1'b0, 1'b0, CcAl, 1'b0);

    // Reset mid-flight discards the writer without an sr_we_o pulse.
    rst = 1'b1;
    next_cycle();
    rst = 1'b0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      check_eq($sformatf("rmid_sr_we_%0d", c), sr_we, 0);
      check_eq($sformatf("rmid_pending_%0d", c), pending, 0);
      next_cycle();
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/flag_update_sequencer.md
Name: flag_update_sequencer

Overview:
- Writer side of the status-flag interface: tracks flag-setting instructions through the DSP48E1 execute pipeline.
- Drives the status-register write enable (sr_we_o) so it lines up with the P output.
- Drives the condition code (condcode_o) into the evaluation stage.
- Stalls issue of a conditional instruction until the flags it depends on are registered.
- Sits between decode/issue and the status-register/control-unit path.

Parameters:
- DSP_LAT, 4: cycles from issue handshake to P valid (flag capture cycle); >= 2.
- COND_LAT, 2: cycles from issue handshake to condition evaluation; 1 <= COND_LAT <= DSP_LAT.
- HAZ_WIN: localparam, = DSP_LAT - COND_LAT; hazard window depth.

Ports:
- clk  in  1  clock.
- rst  in  1  reset; synchronous, active-high.
- issue_valid_i  in  1  decode presents an instruction.
- issue_setflags_i  in  1  instruction updates status flags.
- issue_condcode_i  in  `cond_code_width  instruction condition code.
- ready_o  out  1  issue accepted when issue_valid_i && ready_o.
- flush_i  in  1  kill instructions not yet at condition stage.
- sr_we_o  out  1  status register write enable, aligned with P.
- condcode_o  out  `cond_code_width  condition code for evaluation stage.
- cond_valid_o  out  1  condcode_o belongs to a live instruction.
- pending_o  out  $clog2(DSP_LAT+1)  count of in-flight flag writers.

Behaviour:
- Handshake cycle is cycle 0. Per-stage registers hold {valid, setflags, condcode}; stage k is valid in cycle k+1.
- Outputs:
  - sr_we_o = valid & setflags of stage DSP_LAT-1, i.e. asserted in cycle DSP_LAT.
  - condcode_o and cond_valid_o come from stage COND_LAT-1, i.e. valid in cycle COND_LAT.
  - When cond_valid_o = 0, condcode_o = `AL.
- Hazard:
  - A "conditional" instruction has issue_condcode_i != `AL.
  - ready_o = 0 when issue_valid_i is high, the instruction is conditional, and any stage 0..HAZ_WIN-1 holds valid & setflags. Otherwise ready_o = 1.
  - ready_o is combinational from the pipe plus the issue inputs.
  - If HAZ_WIN = 0, ready_o is constant 1.
  - Guarantee: flags are registered by cycle t+DSP_LAT+1 and the dependant is evaluated no earlier than that.
- Stall inserts a bubble: stage 0 loads valid = 0. Stalled inputs must be held stable by the source.
- Conditional instructions that also set flags obey the stall rule.
- Unconditional (`AL) instructions never stall.
- Flush:
  - flush_i clears valid in stages 0..COND_LAT-2 and drops the instruction handshaking in the same cycle.
  - Stages >= COND_LAT-1 are unaffected; already-evaluated writers still produce sr_we_o.
- pending_o:
  - +1 on an accepted, unflushed setflags instruction.
  - -1 when a setflags instruction leaves stage DSP_LAT-1.
  - -(number of flushed setflags entries) on flush.
  - Simultaneous events net correctly; never underflows.
- Reset: all stage valids 0, sr_we_o = 0, cond_valid_o = 0, condcode_o = `AL, pending_o = 0, ready_o = 1. Reset mid-operation discards all in-flight entries with no sr_we_o pulse.

Optional Feature:
- FLAG_STALL_CNT_EN defined:
  - Adds output stall_cnt_o, 16 bits.
  - Increments each cycle where issue_valid_i && !ready_o.
  - Saturates at 16'hFFFF; cleared by rst.
- Not defined: port and counter are absent and behaviour is otherwise identical.

Decomposition:
- `cond_code_width and the condition encodings (`EQ, `NE, `GE, `LT, `GT, `LE, `AL) come from the shared defines.v.
- Add `DSP_LAT_DEFAULT there.
- One natural sub-module, flag_pipe_stage: a single pipeline stage register (valid, setflags, condcode) with rst and flush-clear. It is instantiated DSP_LAT times via generate.

Test Plan (defaults DSP_LAT=4, COND_LAT=2):
- Reset with valid high: ready_o=1, sr_we_o=0, cond_valid_o=0, condcode_o=`AL, pending_o=0.
- setflags=1, `AL accepted in cycle 0: pending_o=1 in cycles 1..4, sr_we_o=1 in cycle 4 only, pending_o=0 in cycle 5.
- Hazard: setflags `AL in cycle 0, then `EQ non-setflags valid from cycle 1:
  - ready_o=0 in cycles 1-2, accepted in cycle 3.
  - condcode_o=`EQ with cond_valid_o=1 in cycle 5.
  - sr_we_o pulse in cycle 4.
- Back-to-back unconditional setflags in cycles 0,1,2: no stall; sr_we_o high cycles 4,5,6; pending_o peaks at 3.
- Flush: setflags accepted cycle 0, flush_i=1 in cycle 1 with a new issue: stage 0 cleared, new issue dropped, no sr_we_o in cycle 4 or 5, pending_o=0 in cycle 2.
- With FLAG_STALL_CNT_EN, hazard scenario above: stall_cnt_o=2 after cycle 3. Without the macro, the port is absent and the build is clean.
